// File: rtl/cfd_ctrl_pkg.sv
// Shared definitions for the CFD chunk controller, the BRAM port mux and the LBM core.
package cfd_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned CHUNK_WORDS_DEF = 4096;
  localparam int unsigned CNT_W_DEF       = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_XFER      = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/phase_word_counter.sv
// Word counter shared by the transfer and compute phases: clear, increment and terminal flag.
module phase_word_counter #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned CHUNK_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  // One extra bit so a full 2**ADDR_W chunk reaches its terminal value without wrapping.
  localparam logic [ADDR_W:0] TERMINAL = (ADDR_W + 1)'(CHUNK_WORDS - 1);

  logic [ADDR_W:0] count_q, count_d;

  always_comb begin
    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign addr_o = count_q[ADDR_W-1:0];
  assign last_o = (count_q == TERMINAL);

endmodule

// File: rtl/chunk_phase_ctrl.sv
// Sequences each lattice chunk through a DDR->BRAM transfer phase and an LBM compute phase.
module chunk_phase_ctrl
  import cfd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned CHUNK_WORDS = CHUNK_WORDS_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_aresetn,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_chunks,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              lbm_ready,
  input  logic              lbm_done,
  output logic              lbm_start,
  output logic              chunk_transfer_ready,
  output logic [ADDR_W-1:0] DDR_addr,
  output logic              chunk_compute_ready,
  output logic [ADDR_W-1:0] LBM_addr,
  output logic [CNT_W-1:0]  chunk_idx,
  output logic              busy,
  output logic              run_done,
  output logic              err_tlast
);

  state_e            state_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  chunk_idx_q;
  logic              err_q;
  logic [ADDR_W-1:0] ddr_addr_q;

  logic [ADDR_W-1:0] word_addr;
  logic              word_last;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              beat_acc;
  logic              lbm_acc;
  logic              last_chunk;

  assign s_axis_tready = (state_q == ST_XFER);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign lbm_acc       = (state_q == ST_COMPUTE) && lbm_ready;
  assign last_chunk    = (chunk_idx_q == num_q - CNT_W'(1));

  // The terminal word clears the counter, so each phase starts from address 0.
  assign cnt_inc = beat_acc || lbm_acc;
  assign cnt_clr = ((state_q == ST_IDLE) && start)
                || (cnt_inc && word_last)
                || ((state_q == ST_WAIT_DONE) && lbm_done);

  phase_word_counter #(
    .ADDR_W      (ADDR_W),
    .CHUNK_WORDS (CHUNK_WORDS)
  ) u_word_cnt (
    .clk    (m00_axis_aclk),
    .rst_n  (m00_axis_aresetn),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .addr_o (word_addr),
    .last_o (word_last)
  );

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      chunk_idx_q <= '0;
      err_q       <= 1'b0;
      ddr_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_q       <= (num_chunks == '0) ? CNT_W'(1) : num_chunks;
            err_q       <= 1'b0;
            chunk_idx_q <= '0;
            state_q     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_acc) begin
            ddr_addr_q <= word_addr;
            // Length is set by the count alone; tlast is only checked for consistency.
            if (s_axis_tlast != word_last) begin
              err_q <= 1'b1;
            end
            if (word_last) begin
              state_q <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (lbm_acc && word_last) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (lbm_done) begin
            if (last_chunk) begin
              state_q <= ST_DONE;
            end else begin
              chunk_idx_q <= chunk_idx_q + CNT_W'(1);
              state_q     <= ST_XFER;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // DDR_addr shows the accepted beat's address and holds it between beats.
  assign chunk_transfer_ready = beat_acc;
  assign DDR_addr             = beat_acc ? word_addr : ddr_addr_q;
  assign chunk_compute_ready  = lbm_acc;
  assign LBM_addr             = (state_q == ST_COMPUTE) ? word_addr : '0;
  assign lbm_start            = (state_q == ST_LAUNCH);
  assign run_done             = (state_q == ST_DONE);
  assign busy                 = (state_q != ST_IDLE);
  assign chunk_idx            = chunk_idx_q;
  assign err_tlast            = err_q;

endmodule

// File: tb/tb_chunk_phase_ctrl.sv
// Randomized bench for chunk_phase_ctrl: each run is predicted from the chunk/phase rules.
module tb_chunk_phase_ctrl;

  localparam int ADDR_W      = 3;
  localparam int CHUNK_WORDS = 8;
  localparam int CNT_W       = 16;
  localparam int BUDGET      = 100;

  logic              m00_axis_aclk = 1'b0;
  logic              m00_axis_aresetn = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_chunks = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              lbm_ready = 1'b0;
  logic              lbm_done = 1'b0;
  logic              lbm_start;
  logic              chunk_transfer_ready;
  logic [ADDR_W-1:0] DDR_addr;
  logic              chunk_compute_ready;
  logic [ADDR_W-1:0] LBM_addr;
  logic [CNT_W-1:0]  chunk_idx;
  logic              busy;
  logic              run_done;
  logic              err_tlast;

  int n_checks = 0;
  int n_pass   = 0;
  int last_ddr = 0;

  always #5 m00_axis_aclk = ~m00_axis_aclk;

  chunk_phase_ctrl #(
    .ADDR_W      (ADDR_W),
    .CHUNK_WORDS (CHUNK_WORDS),
    .CNT_W       (CNT_W)
  ) dut (
    .m00_axis_aclk        (m00_axis_aclk),
    .m00_axis_aresetn     (m00_axis_aresetn),
    .start                (start),
    .num_chunks           (num_chunks),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .lbm_ready            (lbm_ready),
    .lbm_done             (lbm_done),
    .lbm_start            (lbm_start),
    .chunk_transfer_ready (chunk_transfer_ready),
    .DDR_addr             (DDR_addr),
    .chunk_compute_ready  (chunk_compute_ready),
    .LBM_addr             (LBM_addr),
    .chunk_idx            (chunk_idx),
    .busy                 (busy),
    .run_done             (run_done),
    .err_tlast            (err_tlast)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge m00_axis_aclk);
    #1;
  endtask

  // Outputs expected while the controller sits in IDLE.
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tready"}, int'(s_axis_tready), 0);
    check({tag, "_xfer_rdy"}, int'(chunk_transfer_ready), 0);
    check({tag, "_cmp_rdy"}, int'(chunk_compute_ready), 0);
    check({tag, "_lbm_start"}, int'(lbm_start), 0);
    check({tag, "_run_done"}, int'(run_done), 0);
    check({tag, "_lbm_addr"}, int'(LBM_addr), 0);
    check({tag, "_ddr_addr"}, int'(DDR_addr), last_ddr);
  endtask

  // One run: n_req chunks; vmode/rmode pick tvalid/lbm_ready patterns (0 always, 1 alternate,
  // 2 random); tlast_pos is the beat carrying tlast; poke_start pulses start during the first
  // transfer; abort_at >= 0 drops reset when that compute address is current.
  task automatic run(input int n_req, input int vmode, input int rmode, input int tlast_pos,
                     input bit poke_start, input int abort_at);
    int  n_eff;
    bit  exp_err;
    int  beat;
    int  addr;
    int  cyc;
    int  d;
    n_eff   = (n_req == 0) ? 1 : n_req;
    exp_err = 1'b0;

    start      = 1'b1;
    num_chunks = CNT_W'(n_req);
    #1;
    check_idle("pre_start");
    step();
    start      = 1'b0;
    num_chunks = CNT_W'($urandom);
    check("err_cleared", int'(err_tlast), 0);

    for (int k = 0; k < n_eff; k++) begin
      beat = 0;
      cyc  = 0;
      while (beat < CHUNK_WORDS) begin
        case (vmode)
          0:       s_axis_tvalid = 1'b1;
          1:       s_axis_tvalid = (cyc % 2 == 0);
          default: s_axis_tvalid = 1'($urandom_range(0, 1));
        endcase
        s_axis_tlast = (beat == tlast_pos);
        lbm_done     = 1'($urandom_range(0, 1));
        lbm_ready    = 1'($urandom_range(0, 1));
        start        = poke_start && (k == 0) && (cyc == 2);
        num_chunks   = CNT_W'($urandom);
        #1;
        check("xfer_tready", int'(s_axis_tready), 1);
        check("xfer_strobe", int'(chunk_transfer_ready), int'(s_axis_tvalid));
        check("xfer_no_cmp", int'(chunk_compute_ready), 0);
        check("xfer_chunk_idx", int'(chunk_idx), k);
        if (s_axis_tvalid) begin
          check("ddr_addr", int'(DDR_addr), beat);
          if ((beat == CHUNK_WORDS - 1) != (beat == tlast_pos)) exp_err = 1'b1;
          last_ddr = beat;
          beat++;
        end else begin
          check("ddr_addr_hold", int'(DDR_addr), last_ddr);
        end
        step();
        cyc++;
        if (cyc > BUDGET) begin
          check("xfer_timeout", beat, CHUNK_WORDS);
          return;
        end
      end

      start         = 1'b0;
      lbm_done      = 1'b0;
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tlast  = 1'b0;
      #1;
      check("launch_lbm_start", int'(lbm_start), 1);
      check("launch_tready", int'(s_axis_tready), 0);
      check("launch_xfer_rdy", int'(chunk_transfer_ready), 0);
      check("launch_err_tlast", int'(err_tlast), int'(exp_err));
      step();

      addr = 0;
      cyc  = 0;
      while (addr < CHUNK_WORDS) begin
        case (rmode)
          0:       lbm_ready = 1'b1;
          1:       lbm_ready = (cyc % 2 == 0);
          default: lbm_ready = 1'($urandom_range(0, 1));
        endcase
        lbm_done      = 1'($urandom_range(0, 1));
        s_axis_tvalid = 1'($urandom_range(0, 1));
        if (abort_at >= 0 && addr == abort_at) begin
          lbm_ready        = 1'b1;
          s_axis_tvalid    = 1'b1;
          m00_axis_aresetn = 1'b0;
          last_ddr         = 0;
          #1;
          check_idle("abort");
          check("abort_chunk_idx", int'(chunk_idx), 0);
          check("abort_err_tlast", int'(err_tlast), 0);
          step();
          m00_axis_aresetn = 1'b1;
          lbm_ready        = 1'b0;
          s_axis_tvalid    = 1'b0;
          lbm_done         = 1'b0;
          #1;
          check_idle("post_abort");
          step();
          return;
        end
        #1;
        check("cmp_strobe", int'(chunk_compute_ready), int'(lbm_ready));
        check("lbm_addr", int'(LBM_addr), addr);
        check("cmp_no_xfer", int'(chunk_transfer_ready), 0);
        check("cmp_tready", int'(s_axis_tready), 0);
        check("cmp_lbm_start", int'(lbm_start), 0);
        if (lbm_ready) addr++;
        step();
        cyc++;
        if (cyc > BUDGET) begin
          check("cmp_timeout", addr, CHUNK_WORDS);
          return;
        end
      end

      d = $urandom_range(0, 3);
      for (int w = 0; w < d; w++) begin
        lbm_done  = 1'b0;
        lbm_ready = 1'($urandom_range(0, 1));
        #1;
        check("wait_busy", int'(busy), 1);
        check("wait_run_done", int'(run_done), 0);
        check("wait_cmp_rdy", int'(chunk_compute_ready), 0);
        check("wait_tready", int'(s_axis_tready), 0);
        step();
      end
      lbm_done = 1'b1;
      step();
      lbm_done = 1'b0;
    end

    s_axis_tvalid = 1'b0;
    lbm_ready     = 1'b0;
    #1;
    check("run_done_pulse", int'(run_done), 1);
    check("done_busy", int'(busy), 1);
    step();
    check_idle("post_run");
    check("final_chunk_idx", int'(chunk_idx), n_eff - 1);
    check("final_err_tlast", int'(err_tlast), int'(exp_err));
  endtask

  initial begin
    #2;
    check_idle("reset");
    check("reset_chunk_idx", int'(chunk_idx), 0);
    check("reset_err_tlast", int'(err_tlast), 0);
    step();
    step();
    m00_axis_aresetn = 1'b1;
    step();

    run(1, 0, 0, CHUNK_WORDS - 1, 1'b0, -1);
    run(1, 1, 1, CHUNK_WORDS - 1, 1'b0, -1);
    run(3, 2, 2, CHUNK_WORDS - 1, 1'b0, -1);
    run(0, 0, 0, CHUNK_WORDS - 1, 1'b0, -1);
    run(1, 0, 0, 4, 1'b0, -1);
    run(1, 0, 0, CHUNK_WORDS - 1, 1'b0, -1);
    run(1, 0, 0, CHUNK_WORDS - 1, 1'b0, 3);
    run(2, 0, 2, CHUNK_WORDS - 1, 1'b1, -1);
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, CHUNK_WORDS - 1) : CHUNK_WORDS - 1,
          1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chunk_phase_ctrl.md
Name: chunk_phase_ctrl

Overview:
- Sequences each lattice chunk through two phases: a DDR→BRAM transfer phase, then an LBM compute phase.
- Generates DDR_addr / chunk_transfer_ready and LBM_addr / chunk_compute_ready for the downstream BRAM port mux, which registers them into the BRAM addr/wen.
- Accepts chunk data beats on an AXI-Stream slave handshake; handshakes with the LBM core for compute start/completion.
- Repeats for num_chunks chunks per run.

Parameters:
ADDR_W, 12, BRAM word address width (matches mux addr ports)
CHUNK_WORDS, 4096, words per chunk; must be ≤ 2**ADDR_W and ≥ 2
CNT_W, 16, width of chunk counter

Ports:
m00_axis_aclk  in  1  clock
m00_axis_aresetn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins run (ignored unless IDLE)
num_chunks  in  CNT_W  chunks in run; sampled on start; 0 treated as 1
s_axis_tvalid  in  1  chunk data beat valid
s_axis_tlast  in  1  marks final beat of chunk
s_axis_tready  out  1  beat accept
lbm_ready  in  1  LBM core can consume an address this cycle
lbm_done  in  1  1-cycle pulse; LBM finished chunk writeback
lbm_start  out  1  1-cycle pulse at compute-phase entry
chunk_transfer_ready  out  1  valid DDR_addr this cycle (beat accepted)
DDR_addr  out  ADDR_W  BRAM write address for accepted beat
chunk_compute_ready  out  1  valid LBM_addr this cycle
LBM_addr  out  ADDR_W  BRAM address for LBM access
chunk_idx  out  CNT_W  index of current chunk
busy  out  1  high in any state except IDLE
run_done  out  1  1-cycle pulse when last chunk completes
err_tlast  out  1  sticky; tlast mismatch seen; cleared by start

Behaviour:
- Reset (async, m00_axis_aresetn=0): state IDLE, all outputs 0, counters 0. Reset mid-operation abandons the chunk immediately. No beat is accepted in the reset cycle.
- Interface decision: reset m00_axis_aresetn, asynchronous, active-low; clock m00_axis_aclk. All logic is posedge.
- States: IDLE, XFER, LAUNCH, COMPUTE, WAIT_DONE, DONE.
- IDLE:
  - On start: latch num_chunks (0→1), clear err_tlast, chunk_idx=0, word counter=0 → XFER.
- XFER:
  - s_axis_tready=1 (combinational from state). Beat accepted when tvalid&&tready.
  - Per accepted beat, same cycle: chunk_transfer_ready=1, DDR_addr=word counter; counter increments.
  - Otherwise chunk_transfer_ready=0 and DDR_addr holds its value.
  - tlast check: tlast on a non-final beat, or no tlast on the final beat (CHUNK_WORDS-1), sets err_tlast. Transfer length is governed only by the count.
  - After the final beat: counter→0, go to LAUNCH.
- LAUNCH: lbm_start=1 for exactly one cycle → COMPUTE.
- COMPUTE:
  - chunk_compute_ready = lbm_ready; LBM_addr = word counter.
  - Counter increments on each cycle with lbm_ready=1.
  - After address CHUNK_WORDS-1 is issued → WAIT_DONE.
- WAIT_DONE:
  - Wait for lbm_done.
  - If chunk_idx == latched count-1: → DONE.
  - Else: chunk_idx+1, counter→0, → XFER.
  - An lbm_done pulse in any other state is ignored.
- DONE: run_done=1 for one cycle → IDLE; busy=0 from the next cycle.
- Mutual exclusion: chunk_transfer_ready and chunk_compute_ready are never high in the same cycle. s_axis_tready=0 outside XFER.
- Word counter: ADDR_W+1 bits internally, so CHUNK_WORDS=2**ADDR_W terminates without wrap ambiguity. Address outputs are the low ADDR_W bits.
- start while busy: ignored, with no effect on latched values.
- Throughput:
  - Transfer: 1 beat/cycle.
  - XFER→COMPUTE overhead: 1 cycle (LAUNCH).
  - WAIT_DONE→XFER: 0 extra cycles after lbm_done.

Decomposition:
- Shared package (cfd_ctrl_pkg): state encoding localparams; ADDR_W/CHUNK_WORDS defaults shared with the BRAM port mux and the LBM core.
- One natural sub-module: phase_word_counter (load-zero, increment-enable, terminal-count flag), instantiated once and reused across both phases.

Test Plan:
- Simulation parameters for all scenarios: CHUNK_WORDS=8.
- Reset → all outputs 0, state IDLE. start with num_chunks=1, tvalid held 1, tlast on beat 7 → DDR_addr 0..7 on 8 consecutive chunk_transfer_ready cycles; lbm_start one cycle later; with lbm_ready=1, LBM_addr 0..7; lbm_done → run_done pulse; err_tlast=0.
- tvalid toggled 1,0 every cycle → tready stays 1; exactly 8 transfer strobes over 15 cycles, addresses contiguous, no strobe on idle cycles.
- lbm_ready low on alternate cycles in COMPUTE → chunk_compute_ready mirrors it; LBM_addr advances only on ready cycles and ends at 7; no strobe overlap with transfer.
- num_chunks=3 → chunk_idx 0,1,2; three lbm_start pulses; DDR_addr restarts at 0 each chunk; single run_done after third lbm_done. num_chunks=0 → behaves as 1.
- tlast asserted on beat 4 → err_tlast set; transfer still completes 8 beats. Next start clears err_tlast.
- aresetn dropped during COMPUTE at LBM_addr=3 → outputs 0 immediately, IDLE. start pulse during XFER → ignored, chunk_idx unchanged.
